// File: rtl/freq_scale_ctrl.sv
// Run-time clock-enable divider with valid/ready reconfiguration and clean start/stop.
// Optional: define FREQ_SCALE_CTRL_LOCK_EN to gate `locked` on a settled-period count.
module freq_scale_ctrl #(
  parameter int unsigned      CNT_W        = 8,
  parameter logic [CNT_W-1:0] DEFAULT_HALF = 8'd24,
  parameter int unsigned      LOCK_PERIODS = 4
) (
  input  logic             clk_50MHz,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_half,
  output logic             cfg_ready,
  output logic             clk_out,
  output logic             tick,
  output logic             busy,
  output logic             locked,
  output logic [CNT_W-1:0] cur_half
);

  typedef enum logic [1:0] {StIdle, StRun, StPend} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cur_half_q, cur_half_d;
  logic [CNT_W-1:0] pend_half_q, pend_half_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             stop_q, stop_d;

  logic xfer, running, at_top, period_end, rise;

  assign busy       = (state_q == StPend);
  assign cfg_ready  = !busy && !rst;
  assign xfer       = cfg_valid && cfg_ready;
  assign running    = (state_q != StIdle);
  assign at_top     = (cnt_q == cur_half_q);
  assign period_end = running && at_top && clk_out_q;
  assign rise       = running && at_top && !clk_out_q;

  assign clk_out  = clk_out_q;
  assign tick     = tick_q;
  assign cur_half = cur_half_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cur_half_d  = cur_half_q;
    pend_half_d = pend_half_q;
    clk_out_d   = clk_out_q;
    tick_d      = 1'b0;
    stop_d      = stop_q;
    unique case (state_q)
      StIdle: begin
        cnt_d     = '0;
        clk_out_d = 1'b0;
        stop_d    = 1'b0;
        if (xfer) cur_half_d = cfg_half;
        if (en) state_d = StRun;
      end
      StRun, StPend: begin
        if (!en && !clk_out_q) begin
          // Low phase can be cut short without producing a runt pulse.
          state_d   = StIdle;
          cnt_d     = '0;
          clk_out_d = 1'b0;
          stop_d    = 1'b0;
          if (state_q == StPend) begin
            cur_half_d = pend_half_q;
          end else if (xfer) begin
            cur_half_d = cfg_half;
          end
        end else begin
          cnt_d  = at_top ? '0 : cnt_q + CNT_W'(1);
          tick_d = rise;
          if (at_top) clk_out_d = !clk_out_q;
          if (!en) stop_d = 1'b1;
          if (state_q == StRun && xfer) begin
            pend_half_d = cfg_half;
            state_d     = StPend;
          end
          if (period_end) begin
            stop_d = 1'b0;
            if (state_q == StPend) begin
              cur_half_d = pend_half_q;
              state_d    = StRun;
            end
            if (stop_q || !en) begin
              state_d = StIdle;
              // A value accepted while stopping is applied directly, as in IDLE.
              if (state_q == StRun && xfer) cur_half_d = cfg_half;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      cur_half_q  <= DEFAULT_HALF;
      pend_half_q <= '0;
      clk_out_q   <= 1'b0;
      tick_q      <= 1'b0;
      stop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cur_half_q  <= cur_half_d;
      pend_half_q <= pend_half_d;
      clk_out_q   <= clk_out_d;
      tick_q      <= tick_d;
      stop_q      <= stop_d;
    end
  end

`ifdef FREQ_SCALE_CTRL_LOCK_EN
  localparam int unsigned LockW = (LOCK_PERIODS < 1) ? 1 : $clog2(LOCK_PERIODS + 1);

  logic [LockW-1:0] lock_cnt_q, lock_cnt_d;

  always_comb begin
    lock_cnt_d = lock_cnt_q;
    if (state_q == StIdle || (state_q == StPend && period_end)) begin
      lock_cnt_d = '0;
    end else if (period_end && lock_cnt_q != LockW'(LOCK_PERIODS)) begin
      lock_cnt_d = lock_cnt_q + LockW'(1);
    end
  end

  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      lock_cnt_q <= '0;
    end else begin
      lock_cnt_q <= lock_cnt_d;
    end
  end

  assign locked = running && (lock_cnt_q == LockW'(LOCK_PERIODS));
`else
  logic unused_lock_periods;
  assign unused_lock_periods = (LOCK_PERIODS != 0);
  assign locked = running;
`endif

endmodule

// File: tb/tb_freq_scale_ctrl.sv
// Randomised and directed bench for freq_scale_ctrl against a phase-countdown model.
module tb_freq_scale_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [7:0] cfg_half = 8'd0;
  logic       cfg_ready, clk_out, tick, busy, locked;
  logic [7:0] cur_half;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  freq_scale_ctrl dut (
    .clk_50MHz(clk),
    .rst      (rst),
    .en       (en),
    .cfg_valid(cfg_valid),
    .cfg_half (cfg_half),
    .cfg_ready(cfg_ready),
    .clk_out  (clk_out),
    .tick     (tick),
    .busy     (busy),
    .locked   (locked),
    .cur_half (cur_half)
  );

  always #10 clk = ~clk;

  logic [12:0] act;
  assign act = {clk_out, tick, busy, locked, cfg_ready, cur_half};

  // Model: output level plus cycles left in the current phase.
  bit       m_run = 0, m_hi = 0, m_tick = 0, m_has_pend = 0, m_stop = 0;
  logic [7:0] m_cur = 8'd24, m_pend = 8'd0;
  int       m_left = 0, m_periods = 0;

  function automatic logic [12:0] exp_vec();
    logic lk;
`ifdef FREQ_SCALE_CTRL_LOCK_EN
    lk = m_run && (m_periods >= 4);
`else
    lk = m_run;
`endif
    return {m_hi, m_tick, m_has_pend, lk, !m_has_pend && !rst, m_cur};
  endfunction

  task automatic model_step();
    bit xfer, nstop;
    xfer   = cfg_valid && !m_has_pend && !rst;
    m_tick = 0;
    if (rst) begin
      m_run = 0; m_hi = 0; m_cur = 8'd24; m_has_pend = 0; m_stop = 0; m_periods = 0;
    end else if (!m_run) begin
      if (xfer) m_cur = cfg_half;
      if (en) begin
        m_run = 1; m_hi = 0; m_left = int'(m_cur) + 1; m_periods = 0;
      end
    end else if (!en && !m_hi) begin
      m_run = 0; m_periods = 0; m_stop = 0;
      if (m_has_pend) begin
        m_cur = m_pend; m_has_pend = 0;
      end else if (xfer) begin
        m_cur = cfg_half;
      end
    end else begin
      nstop  = m_stop || !en;
      m_left = m_left - 1;
      if (m_left == 0 && m_hi) begin
        m_hi = 0;
        m_periods++;
        if (m_has_pend) begin
          m_cur = m_pend; m_has_pend = 0; m_periods = 0;
        end
        if (nstop) begin
          m_run = 0; m_stop = 0; m_periods = 0;
          if (xfer) m_cur = cfg_half;
        end else begin
          m_stop = 0;
          if (xfer) begin
            m_pend = cfg_half; m_has_pend = 1;
          end
          m_left = int'(m_cur) + 1;
        end
      end else begin
        if (m_left == 0) begin
          m_hi = 1; m_tick = 1; m_left = int'(m_cur) + 1;
        end
        m_stop = nstop;
        if (xfer) begin
          m_pend = cfg_half; m_has_pend = 1;
        end
      end
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_tick(output bit ok);
    int n = 0;
    while (tick !== 1'b1 && n < 600) begin
      cycle();
      n++;
    end
    ok = (tick === 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; cfg_valid = 1'b0;
    cycle();
    cycle();
    checks++;
    if (act !== 13'h018) begin
      errors++;
      $display("FAIL reset_state: got=%h expected=%h", act, 13'h018);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got=%b expected=1", cfg_ready);
    end
  endtask

  task automatic test_default_run();
    int n = 0, t0, highs = 0;
    int ticks[$];
    en = 1'b1;
    cycle();
    while (clk_out !== 1'b1 && n < 200) begin
      cycle();
      n++;
      checks++;
      if (act !== exp_vec()) begin
        errors++;
        $display("FAIL default_vec: cyc=%0d got=%h expected=%h", cyc, act, exp_vec());
      end
    end
    checks++;
    if (n != 25) begin
      errors++;
      $display("FAIL first_rise: got=%0d cycles expected=25", n);
    end
    t0 = cyc;
    for (int i = 0; i < 100; i++) begin
      cycle();
      if (clk_out === 1'b1) highs++;
      if (tick === 1'b1) ticks.push_back(cyc);
      checks++;
      if (act !== exp_vec()) begin
        errors++;
        $display("FAIL default_vec: cyc=%0d got=%h expected=%h", cyc, act, exp_vec());
      end
    end
    checks++;
    if (highs != 50 || ticks.size() != 2) begin
      errors++;
      $display("FAIL default_duty: got highs=%0d ticks=%0d expected 50 and 2",
               highs, ticks.size());
    end else begin
      checks++;
      if (ticks[0] - t0 != 50 || ticks[1] - ticks[0] != 50) begin
        errors++;
        $display("FAIL default_tick_period: got %0d,%0d expected 50,50",
                 ticks[0] - t0, ticks[1] - ticks[0]);
      end
    end
  endtask

  task automatic test_switch();
    bit ok;
    int n = 0, t_sw, t_lock = -1;
    int ticks[$];
    wait_tick(ok);
    cfg_valid = 1'b1; cfg_half = 8'd4;
    cycle();
    cfg_valid = 1'b0;
    checks++;
    if (!ok || busy !== 1'b1 || cur_half !== 8'd24) begin
      errors++;
      $display("FAIL switch_accept: got busy=%b cur_half=%0d expected busy=1 cur_half=24",
               busy, cur_half);
    end
    while (busy === 1'b1 && n < 200) begin
      cycle();
      n++;
      checks++;
      if (act !== exp_vec()) begin
        errors++;
        $display("FAIL switch_vec: cyc=%0d got=%h expected=%h", cyc, act, exp_vec());
      end
    end
    t_sw = cyc;
    // Accepted in the second high cycle: 24 more high cycles remain before the switch.
    checks++;
    if (n != 24 || cur_half !== 8'd4 || clk_out !== 1'b0) begin
      errors++;
      $display("FAIL switch_point: got n=%0d cur_half=%0d clk_out=%b expected 24, 4, 0",
               n, cur_half, clk_out);
    end
    checks++;
`ifdef FREQ_SCALE_CTRL_LOCK_EN
    if (locked !== 1'b0) begin
      errors++;
      $display("FAIL lock_drop: got locked=%b expected 0", locked);
    end
`else
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL lock_run: got locked=%b expected 1", locked);
    end
`endif
    for (int i = 0; i < 60; i++) begin
      cycle();
      if (tick === 1'b1) ticks.push_back(cyc);
      if (locked === 1'b1 && t_lock < 0) t_lock = cyc;
      checks++;
      if (act !== exp_vec()) begin
        errors++;
        $display("FAIL switch_vec: cyc=%0d got=%h expected=%h", cyc, act, exp_vec());
      end
    end
    checks++;
    if (ticks.size() < 2 || ticks[0] - t_sw != 5 || ticks[1] - ticks[0] != 10) begin
      errors++;
      $display("FAIL switch_ticks: got %0d ticks, first offset %0d expected offset 5 spacing 10",
               ticks.size(), (ticks.size() > 0) ? ticks[0] - t_sw : -1);
    end
`ifdef FREQ_SCALE_CTRL_LOCK_EN
    checks++;
    if (t_lock - t_sw != 40) begin
      errors++;
      $display("FAIL lock_rise: got %0d cycles expected 40", t_lock - t_sw);
    end
`endif
  endtask

  task automatic test_pend_hold();
    bit ok;
    int n = 0;
    wait_tick(ok);
    cfg_valid = 1'b1; cfg_half = 8'd20;
    cycle();
    cfg_half = 8'd9;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (!ok || cfg_ready !== 1'b0 || cur_half !== 8'd4 || busy !== 1'b1) begin
        errors++;
        $display("FAIL pend_hold: got ready=%b cur_half=%0d busy=%b expected 0, 4, 1",
                 cfg_ready, cur_half, busy);
      end
      cycle();
    end
    cfg_valid = 1'b0;
    while (busy === 1'b1 && n < 100) begin
      cycle();
      n++;
    end
    checks++;
    if (busy !== 1'b0 || cur_half !== 8'd20) begin
      errors++;
      $display("FAIL pend_apply: got busy=%b cur_half=%0d expected 0, 20", busy, cur_half);
    end
  endtask

  task automatic test_stop();
    bit ok;
    int n = 0, highs = 3, bad = 0;
    cfg_valid = 1'b1; cfg_half = 8'd24;
    cycle();
    cfg_valid = 1'b0;
    while (busy === 1'b1 && n < 200) begin
      cycle();
      n++;
    end
    wait_tick(ok);
    cycle();
    cycle();
    en = 1'b0;
    while (clk_out === 1'b1 && highs < 100) begin
      cycle();
      if (clk_out === 1'b1) highs++;
      checks++;
      if (act !== exp_vec()) begin
        errors++;
        $display("FAIL stop_vec: cyc=%0d got=%h expected=%h", cyc, act, exp_vec());
      end
    end
    checks++;
    if (!ok || highs != 25 || cur_half !== 8'd24) begin
      errors++;
      $display("FAIL stop_high_len: got %0d cycles expected 25", highs);
    end
    for (int i = 0; i < 60; i++) begin
      cycle();
      if (clk_out !== 1'b0 || tick !== 1'b0 || locked !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stop_idle: got %0d active cycles expected 0", bad);
    end
  endtask

  task automatic test_reset_pend();
    bit ok;
    en = 1'b1;
    cycle();
    wait_tick(ok);
    cfg_valid = 1'b1; cfg_half = 8'd10;
    cycle();
    cfg_valid = 1'b0;
    checks++;
    if (!ok || busy !== 1'b1) begin
      errors++;
      $display("FAIL rstpend_setup: got busy=%b expected 1", busy);
    end
    rst = 1'b1;
    cycle();
    checks++;
    if (act !== 13'h018) begin
      errors++;
      $display("FAIL rstpend_state: got=%h expected=%h", act, 13'h018);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (cfg_ready !== 1'b1 || act !== exp_vec()) begin
      errors++;
      $display("FAIL rstpend_ready: got=%h expected=%h", act, exp_vec());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      en        = ($urandom_range(0, 15) != 0);
      cfg_valid = ($urandom_range(0, 5) == 0);
      cfg_half  = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 40))
                                              : 8'($urandom_range(0, 5));
      rst       = ($urandom_range(0, 299) == 0);
      cycle();
      checks++;
      if (act !== exp_vec()) begin
        errors++;
        $display("FAIL random_vec: cyc=%0d got=%h expected=%h", cyc, act, exp_vec());
      end
    end
    rst = 1'b0; cfg_valid = 1'b0;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_default_run();
    test_switch();
    test_pend_hold();
    test_stop();
    test_reset_pend();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
